nibble_add_seq: RTL and testbench

Sequencing controller that time-shares one external 4-bit ripple-carry adder slice to add two wide operands, one nibble per clock, LSB first. The controller latches operands, presents one nibble pair and the running carry to the slice each cycle, and captures the slice sum and carry-out. It assembles the full result and returns it over a valid/ready handshake. It sits between a requesting datapath and the shared `fulladder_4bit`-style slice, which stays purely combinational.

---
 rtl/nibble_add_seq.sv | 95 +++++++++
 tb/tb_nibble_add_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// Adds two NIBBLES*4-bit operands through one shared external 4-bit adder slice, LSB nibble first.
// Result is valid NIBBLES cycles after accept; it is held in DONE until result_ready, and no new request is taken until then.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             slice_a,
  output logic [3:0]             slice_b,
  output logic                   slice_cin,
  input  logic [3:0]             slice_sum,
  input  logic                   slice_cout,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     carry_reg;
  logic [NIBBLES-1:0][3:0]  a_nib;
  logic [NIBBLES-1:0][3:0]  b_nib;
  logic [NIBBLES-1:0][3:0]  res_nib;
  logic                     cout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_nib     <= '0;
      b_nib     <= '0;
      res_nib   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_nib     <= op_a;
            b_nib     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
            res_nib   <= '0;
            cout_reg  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_nib[idx] <= slice_sum;
          carry_reg    <= slice_cout;
          // Last nibble: the slice carry-out is the final carry of the whole add.
          if (idx == LAST) begin
            cout_reg <= slice_cout;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state == IDLE) && !rst;
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign result       = res_nib;
  assign cout         = cout_reg;

  // Slice inputs are forced to zero outside RUN so the shared slice sees a quiet bus.
  assign slice_a   = (state == RUN) ? a_nib[idx] : 4'h0;
  assign slice_b   = (state == RUN) ? b_nib[idx] : 4'h0;
  assign slice_cin = (state == RUN) ? carry_reg  : 1'b0;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq (NIBBLES=4) with a behavioural 4-bit adder slice.
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] op_a, op_b;
  logic        op_cin;
  logic [3:0]  slice_a, slice_b, slice_sum;
  logic        slice_cin, slice_cout;
  logic        result_valid, result_ready;
  logic [15:0] result;
  logic        cout, busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] sa_seq [4];
  logic       sc_seq [4];

  always #5 clk = ~clk;

  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .cout(cout), .busy(busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        co;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction with result_ready high; checks latency, result and return to IDLE.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] er, input logic eco, input string tag);
    check({tag, "_start_ready"}, start_ready, 1);
    start_valid = 1'b1;
    op_a = a; op_b = b; op_cin = c;
    tick();
    start_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int k = 0; k < 4; k++) begin
      sa_seq[k] = slice_a;
      sc_seq[k] = slice_cin;
      check({tag, "_early_valid"}, result_valid, 0);
      tick();
    end
    check({tag, "_valid"}, result_valid, 1);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, cout, eco);
    check({tag, "_slice_done"}, slice_a, 0);
    tick();
    check({tag, "_idle_valid"}, result_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_held"}, result, er);
  endtask

  initial begin
    vec_t        vecs [8];
    logic [3:0]  exp_sa [4];
    logic        exp_sc [4];
    logic [16:0] expq [$];
    logic [16:0] e;
    int          last, sent, got;
    logic        acc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    exp_sa[0] = 4'h4; exp_sa[1] = 4'h3; exp_sa[2] = 4'h2; exp_sa[3] = 4'h1;
    exp_sc[0] = 1'b0; exp_sc[1] = 1'b1; exp_sc[2] = 1'b1; exp_sc[3] = 1'b1;

    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b1;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    tick();
    check("rst_start_ready_low", start_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_slice", {slice_a, slice_b, slice_cin}, 0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].co, $sformatf("vec%0d", i));
      if (i == 0) for (int k = 0; k < 4; k++) check($sformatf("vec0_slice_a%0d", k), sa_seq[k], exp_sa[k]);
      if (i == 1) for (int k = 0; k < 4; k++) check($sformatf("vec1_slice_cin%0d", k), sc_seq[k], exp_sc[k]);
    end

    // Backpressure in DONE: new requests must be ignored and result held.
    result_ready = 1'b0;
    start_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0;
    tick();
    start_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", result_valid, 1);
      check("bp_start_ready", start_ready, 0);
      check("bp_result", result, 16'h2345);
      check("bp_cout", cout, 0);
      start_valid = (i % 2 == 0);
      op_a = 16'hDEAD; op_b = 16'hBEEF; op_cin = 1'b1;
      tick();
    end
    check("bp_still_valid", result_valid, 1);
    check("bp_still_result", result, 16'h2345);
    result_ready = 1'b1;
    start_valid = 1'b1;
    tick();
    check("bp_release_idle", busy, 0);
    check("bp_release_ready", start_ready, 1);
    check("bp_release_held", result, 16'h2345);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "bp_next");

    // Reset during the second RUN cycle discards the partial sum.
    start_valid = 1'b1; op_a = 16'hABCD; op_b = 16'h1111; op_cin = 1'b0;
    tick();
    start_valid = 1'b0;
    tick();
    check("mr_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    check("mr_busy", busy, 0);
    check("mr_result", result, 0);
    check("mr_cout", cout, 0);
    check("mr_valid", result_valid, 0);
    check("mr_start_ready_low", start_ready, 0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("mr_no_valid", result_valid, 0);
      tick();
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "mr_next");

    // Back-to-back random requests; accepts must be exactly 6 cycles apart.
    last = -1; sent = 0; got = 0;
    op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom);
    start_valid = 1'b1;
    for (int c = 0; c < 120 && got < 8; c++) begin
      acc = start_ready && start_valid;
      if (acc) begin
        expq.push_back({1'b0, op_a} + {1'b0, op_b} + {16'b0, op_cin});
        if (last >= 0) check("rand_spacing", c - last, 6);
        last = c;
        sent++;
      end
      if (result_valid) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("rand_result", result, e[15:0]);
          check("rand_cout", cout, e[16]);
        end else begin
          check("rand_spurious_valid", result_valid, 0);
        end
        got++;
      end
      tick();
      if (acc) begin
        op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom);
        if (sent == 8) start_valid = 1'b0;
      end
    end
    check("rand_count", got, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
